tug_referee: RTL and testbench
==============================

TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning round wins needed to take the match (legal 1..7).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 4, meaning post-round input lockout length in clk cycles (legal 1..255).
REQ-003 The block SHALL have port clk  input  1  meaning the sole clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port L  input  1  meaning the left-player press, one-cycle pulse, already synchronised and edge-detected.
REQ-006 The block SHALL have port R  input  1  meaning the right-player press, same form as L.
REQ-007 The block SHALL have port led  input  [9:1]  meaning the current playfield from the lights stage, where led[9] is the left end and led[1] is the right end.
REQ-008 The block SHALL have port wL  output  1  meaning a one-cycle left-round-win pulse that drives the lights centre reset.
REQ-009 The block SHALL have port wR  output  1  meaning a one-cycle right-round-win pulse, same use as wL.
REQ-010 The block SHALL have port play_en  output  1  meaning the press gate, which top level ANDs into the L/R inputs of the lights stage.
REQ-011 The block SHALL have port scoreL  output  [2:0]  meaning the left round-win count.
REQ-012 The block SHALL have port scoreR  output  [2:0]  meaning the right round-win count.
REQ-013 The block SHALL have port hexL  output  [6:0]  meaning the active-low 7-segment image of scoreL.
REQ-014 The block SHALL have port hexR  output  [6:0]  meaning the active-low 7-segment image of scoreR.
REQ-015 The block SHALL have port champ  output  [1:0]  meaning the match winner: 00 none, 10 left, 01 right.

Function
REQ-016 The block SHALL register a left win when the state is PLAY, L=1, R=0 and led[9]=1, all sampled in the same cycle.
REQ-017 The block SHALL register a right win when the state is PLAY, R=1, L=0 and led[1]=1, all sampled in the same cycle.
REQ-018 The block SHALL treat L=R=1 in the same cycle as no win, regardless of led.
REQ-019 The block SHALL have the FSM states PLAY, LOCKOUT and DONE.
REQ-020 In PLAY, a qualifying left win SHALL assert wL for exactly the next cycle and increment scoreL on that same edge; a right win SHALL do the same with wR and scoreR.
REQ-021 After a win, if the new score is below WIN_SCORE, the FSM SHALL go to LOCKOUT; if the new score equals WIN_SCORE, it SHALL go to DONE.
REQ-022 LOCKOUT SHALL hold play_en=0 for exactly LOCK_CYCLES cycles, counted by an 8-bit down-counter loaded on entry, and then return to PLAY.
REQ-023 DONE SHALL be terminal until reset, with play_en=0, champ set to the winning side, and scores frozen.
REQ-024 play_en SHALL be 1 only in PLAY; it is registered and is the FSM decode, with no combinational path from L or R.
REQ-025 The block SHALL ignore presses and led while in LOCKOUT or DONE, with no wins, no pulses and no score change.
REQ-026 Scores SHALL never exceed WIN_SCORE and never wrap; there SHALL be no 7-to-0 rollover.
REQ-027 hexL and hexR SHALL be a combinational decode of the registered scores (0..7), and all other outputs SHALL be registered.
REQ-028 wL and wR SHALL never be high in the same cycle, and each SHALL never be high for two consecutive cycles.

Reset
REQ-029 Reset SHALL put the FSM in PLAY with wL=wR=0, play_en=1, scoreL=scoreR=0, hexL=hexR=7'b1000000, champ=00 and the lockout counter at 0.
REQ-030 Reset asserted in any state, including mid-LOCKOUT or DONE, SHALL take effect on the next edge and override a win in the same cycle.

Structure
REQ-031 Package tug_pkg SHALL hold the FSM state enum, the score width constant (3), the champ encodings, and the active-low 7-segment table for digits 0-7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
REQ-032 Sub-module score_seg7 SHALL perform the 3-bit to 7-segment decode and SHALL be instantiated twice, once per score.

Verification
REQ-033 After reset, with led=9'b000010000 and L=1 for one cycle, the bench SHALL see no wL and play_en still 1.
REQ-034 With led[9]=1 and an L pulse, the bench SHALL see wL=1 for 1 cycle, scoreL=1, hexL=1111001, and play_en=0 for exactly 4 cycles before returning to 1.
REQ-035 With led[9]=1 and led[1]=1 forced and L=R=1 in the same cycle, the bench SHALL see no pulse and no score change.
REQ-036 Driving seven left wins with WIN_SCORE=7 SHALL give state DONE, champ=10 and scoreL=7; further L pulses with led[9]=1 SHALL leave wL=0 and scoreL=7.
REQ-037 Asserting reset on the 2nd LOCKOUT cycle SHALL return play_en=1 and scores=0 on the next edge, and an R pulse with led[1]=1 one cycle later SHALL give wR=1.
REQ-038 Pulsing R with led[1]=1 during LOCKOUT SHALL be ignored, with scoreR unchanged and wR=0.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee: FSM states,
// score width, match-winner encodings and the active-low 7-segment table.
package tug_pkg;

  localparam int SCORE_W = 3;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [1:0] CHAMP_NONE  = 2'b00;
  localparam logic [1:0] CHAMP_LEFT  = 2'b10;
  localparam logic [1:0] CHAMP_RIGHT = 2'b01;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7_decode(input logic [SCORE_W-1:0] digit);
    logic [6:0] seg;
    case (digit)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_seg7.sv
// Combinational score-to-display decode, one instance per player.
module score_seg7
  import tug_pkg::*;
(
  input  logic [SCORE_W-1:0] score_i,
  output logic [6:0]         seg_o
);

  assign seg_o = seg7_decode(score_i);

endmodule

// File: rtl/tug_referee.sv
// Referee for the tug-of-war game: detects round wins at the playfield ends,
// keeps scores, gates presses during the post-round lockout and declares the match winner.
module tug_referee
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int LOCK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               L,
  input  logic               R,
  input  logic [9:1]         led,
  output logic               wL,
  output logic               wR,
  output logic               play_en,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic [6:0]         hexL,
  output logic [6:0]         hexR,
  output logic [1:0]         champ
);

  localparam logic [SCORE_W-1:0] WIN_Q  = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         LOCK_Q = 8'(LOCK_CYCLES);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wl_q, wl_d;
  logic               wr_q, wr_d;
  logic               pe_q, pe_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         champ_q, champ_d;
  logic               win_l, win_r;
  logic               unused_led;

  // Only the two end lights decide a round; the interior is irrelevant here.
  assign unused_led = ^led[8:2];

  assign win_l = (state_q == ST_PLAY) && L && !R && led[9];
  assign win_r = (state_q == ST_PLAY) && R && !L && led[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wl_d      = 1'b0;
    wr_d      = 1'b0;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    champ_d   = champ_q;
    case (state_q)
      ST_PLAY: begin
        if (win_l && (score_l_q < WIN_Q)) begin
          wl_d      = 1'b1;
          score_l_d = score_l_q + 1'b1;
          if (score_l_d == WIN_Q) begin
            state_d = ST_DONE;
            champ_d = CHAMP_LEFT;
          end else begin
            state_d = ST_LOCKOUT;
            cnt_d   = LOCK_Q;
          end
        end else if (win_r && (score_r_q < WIN_Q)) begin
          wr_d      = 1'b1;
          score_r_d = score_r_q + 1'b1;
          if (score_r_d == WIN_Q) begin
            state_d = ST_DONE;
            champ_d = CHAMP_RIGHT;
          end else begin
            state_d = ST_LOCKOUT;
            cnt_d   = LOCK_Q;
          end
        end
      end
      // The counter holds the remaining gated cycles, including the current one.
      ST_LOCKOUT: begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d   = 8'd0;
          state_d = ST_PLAY;
        end
      end
      ST_DONE: ;
      default: state_d = ST_PLAY;
    endcase
    pe_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PLAY;
      cnt_q     <= 8'd0;
      wl_q      <= 1'b0;
      wr_q      <= 1'b0;
      pe_q      <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      champ_q   <= CHAMP_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wl_q      <= wl_d;
      wr_q      <= wr_d;
      pe_q      <= pe_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      champ_q   <= champ_d;
    end
  end

  assign wL      = wl_q;
  assign wR      = wr_q;
  assign play_en = pe_q;
  assign scoreL  = score_l_q;
  assign scoreR  = score_r_q;
  assign champ   = champ_q;

  score_seg7 u_seg_l (.score_i(score_l_q), .seg_o(hexL));
  score_seg7 u_seg_r (.score_i(score_r_q), .seg_o(hexR));

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: directed vector table, match sequences
// and randomized play against a round/score-level reference model.
module tb_tug_referee;

  localparam int WIN  = 7;
  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset, L, R;
  logic [9:1] led;
  logic       wL, wR, play_en;
  logic [2:0] scoreL, scoreR;
  logic [6:0] hexL, hexR;
  logic [1:0] champ;

  always #5 clk = ~clk;

  tug_referee #(.WIN_SCORE(WIN), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .led(led),
    .wL(wL), .wR(wR), .play_en(play_en),
    .scoreL(scoreL), .scoreR(scoreR), .hexL(hexL), .hexR(hexR), .champ(champ)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_ref [0:7];

  // Reference model: round scores, remaining gated cycles, match over flag.
  int         m_sl = 0, m_sr = 0, m_lock_left = 0;
  bit         m_over = 0;
  logic [1:0] m_champ = 2'b00;
  bit         m_wl = 0, m_wr = 0, m_pe = 1;

  typedef struct {
    bit         rs, l, r;
    logic [9:1] led;
    bit         ewl, ewr, epe;
    int         esl, esr;
  } vec_t;

  vec_t vt [12];

  localparam logic [9:1] LED_MID   = 9'b000010000;
  localparam logic [9:1] LED_LEFT  = 9'b100000000;
  localparam logic [9:1] LED_RIGHT = 9'b000000001;
  localparam logic [9:1] LED_BOTH  = 9'b100000001;
  localparam logic [9:1] LED_NONE  = 9'b000000000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rs, input bit l, input bit r, input logic [9:1] ld);
    m_wl = 0;
    m_wr = 0;
    if (rs) begin
      m_sl = 0; m_sr = 0; m_lock_left = 0; m_over = 0; m_champ = 2'b00; m_pe = 1;
    end else if (m_over) begin
      m_pe = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      m_pe = (m_lock_left == 0);
    end else if (l && !r && ld[9]) begin
      m_sl++; m_wl = 1; m_pe = 0;
      if (m_sl == WIN) begin m_over = 1; m_champ = 2'b10; end
      else m_lock_left = LOCK;
    end else if (r && !l && ld[1]) begin
      m_sr++; m_wr = 1; m_pe = 0;
      if (m_sr == WIN) begin m_over = 1; m_champ = 2'b01; end
      else m_lock_left = LOCK;
    end
  endtask

  task automatic step(input bit rs, input bit l, input bit r, input logic [9:1] ld);
    @(negedge clk);
    reset = rs; L = l; R = r; led = ld;
    @(posedge clk);
    model_edge(rs, l, r, ld);
    #1;
    chk("wL", wL, m_wl);
    chk("wR", wR, m_wr);
    chk("play_en", play_en, m_pe);
    chk("scoreL", scoreL, m_sl);
    chk("scoreR", scoreR, m_sr);
    chk("champ", champ, m_champ);
    chk("hexL", hexL, seg_ref[m_sl]);
    chk("hexR", hexR, seg_ref[m_sr]);
    chk("no_dual_pulse", wL & wR, 0);
  endtask

  task automatic play_match(input bit left_side);
    step(1, 0, 0, LED_NONE);
    for (int k = 1; k <= WIN; k++) begin
      if (left_side) step(0, 1, 0, LED_LEFT);
      else           step(0, 0, 1, LED_RIGHT);
      chk(left_side ? "match_wL" : "match_wR", left_side ? wL : wR, 1);
      chk("match_score", left_side ? scoreL : scoreR, k);
      if (k < WIN)
        for (int j = 0; j < LOCK; j++) step(0, 0, 0, LED_NONE);
    end
    chk("match_champ", champ, left_side ? 2'b10 : 2'b01);
    chk("match_pe", play_en, 0);
  endtask

  initial begin
    seg_ref[0] = 7'b1000000; seg_ref[1] = 7'b1111001;
    seg_ref[2] = 7'b0100100; seg_ref[3] = 7'b0110000;
    seg_ref[4] = 7'b0011001; seg_ref[5] = 7'b0010010;
    seg_ref[6] = 7'b0000010; seg_ref[7] = 7'b1111000;
    reset = 1'b1; L = 1'b0; R = 1'b0; led = LED_NONE;

    //        rs l  r  led        wl wr pe sl sr
    vt[0]  = '{1, 0, 0, LED_NONE,  0, 0, 1, 0, 0};
    vt[1]  = '{0, 1, 0, LED_MID,   0, 0, 1, 0, 0};
    vt[2]  = '{0, 1, 0, LED_LEFT,  1, 0, 0, 1, 0};
    vt[3]  = '{0, 0, 0, LED_NONE,  0, 0, 0, 1, 0};
    vt[4]  = '{0, 0, 1, LED_RIGHT, 0, 0, 0, 1, 0};
    vt[5]  = '{0, 0, 0, LED_NONE,  0, 0, 0, 1, 0};
    vt[6]  = '{0, 0, 0, LED_NONE,  0, 0, 1, 1, 0};
    vt[7]  = '{0, 1, 1, LED_BOTH,  0, 0, 1, 1, 0};
    vt[8]  = '{0, 0, 1, LED_RIGHT, 0, 1, 0, 1, 1};
    vt[9]  = '{0, 0, 0, LED_NONE,  0, 0, 0, 1, 1};
    vt[10] = '{1, 0, 0, LED_NONE,  0, 0, 1, 0, 0};
    vt[11] = '{0, 0, 1, LED_RIGHT, 0, 1, 0, 0, 1};

    for (int i = 0; i < 12; i++) begin
      step(vt[i].rs, vt[i].l, vt[i].r, vt[i].led);
      chk($sformatf("vec%0d_wL", i), wL, vt[i].ewl);
      chk($sformatf("vec%0d_wR", i), wR, vt[i].ewr);
      chk($sformatf("vec%0d_play_en", i), play_en, vt[i].epe);
      chk($sformatf("vec%0d_scoreL", i), scoreL, vt[i].esl);
      chk($sformatf("vec%0d_scoreR", i), scoreR, vt[i].esr);
      if (i == 2) chk("vec2_hexL", hexL, 7'b1111001);
    end

    // Left match to completion, then presses must be ignored.
    play_match(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, LED_LEFT);
      chk("done_wL", wL, 0);
      chk("done_scoreL", scoreL, 7);
      step(0, 0, 1, LED_RIGHT);
      chk("done_wR", wR, 0);
    end
    // Reset out of DONE, and reset overriding a qualifying win.
    step(1, 1, 0, LED_LEFT);
    chk("rst_over_win_wL", wL, 0);
    chk("rst_over_win_scoreL", scoreL, 0);
    chk("rst_champ", champ, 2'b00);
    chk("rst_hexL", hexL, 7'b1000000);
    play_match(1'b0);

    step(1, 0, 0, LED_NONE);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 9'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
